// File: rtl/gtrg_dav_fifo.sv
// GTRG DAV/BX FIFO: per-channel DAV delay alignment, delayed L1A push, and a
// 2**ADDR_W-deep {DAV, BX} FIFO. Optional DAV scope capture: GTRG_DAV_SCOPE_EN.
module gtrg_dav_fifo #(
    parameter int NCH    = 7,
    parameter int ADDR_W = 10,
    parameter int BX_W   = 12,
    parameter int BX_MAX = 3563
) (
    input  logic                CLK,
    input  logic                RST_B,
    input  logic                PUSH,
    input  logic                POP,
    input  logic                BC0,
    input  logic [NCH-1:0]      DAV,
    input  logic [NCH-1:0]      KILL,
    input  logic [4*NCH-1:0]    DAVDLY,
    input  logic [4:0]          PUSHDLY,
    input  logic [ADDR_W:0]     AFULL_THR,
    output logic                DPUSH,
    output logic [NCH-1:0]      DAVSOUT,
    output logic [BX_W-1:0]     BXOUT,
    output logic                EMPTY_B,
    output logic                FULL,
    output logic                AFULL,
    output logic [ADDR_W:0]     COUNT,
    output logic                FIFOERR,
    output logic                OVFL
`ifdef GTRG_DAV_SCOPE_EN
    ,
    output logic [5*NCH-1:0]    SCOPE
`endif
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam int              ENT_W    = NCH + BX_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [NCH-1:0]    dav_pipe [16];
    logic [NCH-1:0]    dav_dly;
    logic [31:0]       push_pipe;
    logic [BX_W-1:0]   bx_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ENT_W-1:0]  ram [DEPTH];
    logic              wr;
    logic              rd;
    logic              drop;
    logic              bad_pop;

    // Tap 0 is already one clock behind DAV, so code c yields c+1 clocks total.
    always_comb begin
        dav_dly = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            dav_dly[i] = dav_pipe[DAVDLY[4*i +: 4]][i];
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int unsigned k = 0; k < 16; k++) begin
                dav_pipe[k] <= '0;
            end
            push_pipe <= '0;
            DPUSH     <= 1'b0;
        end else begin
            dav_pipe[0] <= DAV & ~KILL;
            for (int unsigned k = 1; k < 16; k++) begin
                dav_pipe[k] <= dav_pipe[k-1];
            end
            push_pipe <= {push_pipe[30:0], PUSH};
            DPUSH     <= push_pipe[PUSHDLY];
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            bx_cnt <= '0;
        end else if (BC0) begin
            bx_cnt <= '0;
        end else if (bx_cnt == BX_W'(BX_MAX)) begin
            bx_cnt <= '0;
        end else begin
            bx_cnt <= bx_cnt + BX_W'(1);
        end
    end

    assign FULL    = (COUNT == CNT_FULL);
    assign EMPTY_B = (COUNT != '0);
    assign AFULL   = (COUNT >= AFULL_THR);

    // A pop while full frees the slot being written, so the push is accepted.
    always_comb begin
        wr      = DPUSH & (~FULL | POP);
        rd      = POP & EMPTY_B;
        drop    = DPUSH & FULL & ~POP;
        bad_pop = POP & ~EMPTY_B;
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            COUNT   <= '0;
            FIFOERR <= 1'b0;
            OVFL    <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr, rd})
                2'b10:   COUNT <= COUNT + (ADDR_W + 1)'(1);
                2'b01:   COUNT <= COUNT - (ADDR_W + 1)'(1);
                default: COUNT <= COUNT;
            endcase
            FIFOERR <= drop | bad_pop;
            if (drop) OVFL <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr) ram[wr_ptr] <= {dav_dly, bx_cnt};
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            DAVSOUT <= '0;
            BXOUT   <= '0;
        end else begin
            {DAVSOUT, BXOUT} <= ram[rd_ptr];
        end
    end

`ifdef GTRG_DAV_SCOPE_EN
    logic [NCH-1:0] scope_h [4];

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int unsigned k = 0; k < 4; k++) begin
                scope_h[k] <= '0;
            end
            SCOPE <= '0;
        end else begin
            scope_h[0] <= dav_dly;
            for (int unsigned k = 1; k < 4; k++) begin
                scope_h[k] <= scope_h[k-1];
            end
            if (DPUSH) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    SCOPE[5*i] <= dav_dly[i];
                    for (int unsigned k = 0; k < 4; k++) begin
                        SCOPE[5*i+1+k] <= scope_h[k][i];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_gtrg_dav_fifo.sv
// Bench for gtrg_dav_fifo: cycle-history reference model feeding a scoreboard
// queue, a negedge monitor, and directed plus randomized stimulus.
module tb_gtrg_dav_fifo;

    localparam int NCH    = 7;
    localparam int ADDR_W = 10;
    localparam int BX_W   = 12;
    localparam int BX_MAX = 3563;
    localparam int DEPTH  = 1024;
    localparam int HN     = 16384;

    logic                CLK;
    logic                RST_B;
    logic                PUSH;
    logic                POP;
    logic                BC0;
    logic [NCH-1:0]      DAV;
    logic [NCH-1:0]      KILL;
    logic [4*NCH-1:0]    DAVDLY;
    logic [4:0]          PUSHDLY;
    logic [ADDR_W:0]     AFULL_THR;
    logic                DPUSH;
    logic [NCH-1:0]      DAVSOUT;
    logic [BX_W-1:0]     BXOUT;
    logic                EMPTY_B;
    logic                FULL;
    logic                AFULL;
    logic [ADDR_W:0]     COUNT;
    logic                FIFOERR;
    logic                OVFL;
`ifdef GTRG_DAV_SCOPE_EN
    logic [5*NCH-1:0]    SCOPE;
`endif

    gtrg_dav_fifo #(
        .NCH    (NCH),
        .ADDR_W (ADDR_W),
        .BX_W   (BX_W),
        .BX_MAX (BX_MAX)
    ) dut (
        .CLK       (CLK),
        .RST_B     (RST_B),
        .PUSH      (PUSH),
        .POP       (POP),
        .BC0       (BC0),
        .DAV       (DAV),
        .KILL      (KILL),
        .DAVDLY    (DAVDLY),
        .PUSHDLY   (PUSHDLY),
        .AFULL_THR (AFULL_THR),
        .DPUSH     (DPUSH),
        .DAVSOUT   (DAVSOUT),
        .BXOUT     (BXOUT),
        .EMPTY_B   (EMPTY_B),
        .FULL      (FULL),
        .AFULL     (AFULL),
        .COUNT     (COUNT),
        .FIFOERR   (FIFOERR),
        .OVFL      (OVFL)
`ifdef GTRG_DAV_SCOPE_EN
        ,
        .SCOPE     (SCOPE)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Reference model: input history per edge since reset; outputs derived
    // from how many clocks back each stimulus lands.
    logic [NCH-1:0]          dav_hist  [HN];
    logic                    push_hist [HN];
    logic [NCH+BX_W-1:0]     exp_q [$];
    int                      cyc        = 0;
    int                      m_cnt      = 0;
    int                      m_cnt_prev = 0;
    int                      m_bx_base  = 0;
    int                      idx;
    bit                      m_dp   = 0;
    bit                      m_err  = 0;
    bit                      m_ovfl = 0;
    bit                      m_full, m_empty, m_wr, m_rd;
    logic [BX_W-1:0]         m_bx = '0;
    logic [NCH-1:0]          m_dd;

    always @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            cyc = 0; m_cnt = 0; m_cnt_prev = 0; m_bx_base = 0;
            m_dp = 0; m_err = 0; m_ovfl = 0; m_bx = '0;
            exp_q.delete();
        end else begin
            cyc++;
            dav_hist[cyc % HN]  = DAV & ~KILL;
            push_hist[cyc % HN] = PUSH;
            for (int i = 0; i < NCH; i++) begin
                idx = cyc - 1 - int'(DAVDLY[4*i +: 4]);
                m_dd[i] = (idx >= 1) ? dav_hist[idx % HN][i] : 1'b0;
            end
            m_full  = (m_cnt == DEPTH);
            m_empty = (m_cnt == 0);
            m_wr    = m_dp && (!m_full || POP);
            m_rd    = POP && !m_empty;
            if (m_wr) exp_q.push_back({m_dd, m_bx});
            m_cnt_prev = m_cnt;
            m_cnt      = m_cnt + int'(m_wr) - int'(m_rd);
            m_err      = (m_dp && m_full && !POP) || (POP && m_empty);
            if (m_dp && m_full && !POP) m_ovfl = 1;
            idx  = cyc - 1 - int'(PUSHDLY);
            m_dp = (idx >= 1) ? push_hist[idx % HN] : 1'b0;
            if (BC0) m_bx_base = cyc;
            m_bx = BX_W'((cyc - m_bx_base) % (BX_MAX + 1));
        end
    end

    logic [NCH+BX_W-1:0] sb_e;

    always @(negedge CLK) begin
        if (RST_B) begin
            check("dpush",   32'(DPUSH),   32'(m_dp));
            check("count",   32'(COUNT),   32'(m_cnt));
            check("empty_b", 32'(EMPTY_B), 32'(m_cnt != 0));
            check("full",    32'(FULL),    32'(m_cnt == DEPTH));
            check("afull",   32'(AFULL),   32'(m_cnt >= int'(AFULL_THR)));
            check("fifoerr", 32'(FIFOERR), 32'(m_err));
            check("ovfl",    32'(OVFL),    32'(m_ovfl));
            if (POP && m_cnt > 0) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("sb_underflow");
                end else begin
                    sb_e = exp_q.pop_front();
                    check("head", 32'({DAVSOUT, BXOUT}), 32'(sb_e));
                end
            end
        end
    end

    bit pop_last = 0;

    task automatic tick();
        @(posedge CLK);
        pop_last = POP;
        #2;
        PUSH = 0; POP = 0; BC0 = 0; DAV = '0;
    endtask

    function automatic bit head_ok();
        return (m_cnt > 0) && (m_cnt_prev > 0) && !pop_last;
    endfunction

    task automatic wait_head(input string name);
        for (int k = 0; k < 16; k++) begin
            if (head_ok()) return;
            tick();
        end
        timeout_fail(name);
    endtask

    task automatic wait_dp(input string name);
        for (int k = 0; k < 40; k++) begin
            if (m_dp) return;
            tick();
        end
        timeout_fail(name);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (m_cnt == 0 && !m_dp) return;
            if (head_ok()) POP = 1;
            tick();
        end
        timeout_fail("drain");
    endtask

    task automatic do_reset();
        RST_B = 0;
        #1;
        check("rst_count",   32'(COUNT),   0);
        check("rst_empty_b", 32'(EMPTY_B), 0);
        check("rst_full",    32'(FULL),    0);
        check("rst_afull",   32'(AFULL),   32'(AFULL_THR == 0));
        check("rst_dpush",   32'(DPUSH),   0);
        check("rst_davsout", 32'(DAVSOUT), 0);
        check("rst_bxout",   32'(BXOUT),   0);
        check("rst_fifoerr", 32'(FIFOERR), 0);
        check("rst_ovfl",    32'(OVFL),    0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        pop_last = 0;
        RST_B = 1;
    endtask

    initial begin
        RST_B = 1; PUSH = 0; POP = 0; BC0 = 0; DAV = '0; KILL = '0;
        DAVDLY = '0; PUSHDLY = '0; AFULL_THR = '0;
        #2;
        do_reset();

        // Aligned DAV: channel 2 delayed 4 clocks meets DPUSH from PUSH 2 clocks later.
        DAVDLY = 28'h0000300; AFULL_THR = 11'd8;
        tick(); DAV = 7'b0000100;
        tick();
        tick(); PUSH = 1;
        tick();
        wait_head("t1_head");
        check("t1_davsout", 32'(DAVSOUT), 32'h04);
        POP = 1;
        tick();

        // Fill to capacity, then one dropped push.
        for (int k = 0; k < DEPTH; k++) begin
            DAV = 7'($urandom); PUSH = 1;
            tick();
        end
        repeat (4) tick();
        check("t2_full",  32'(FULL),  1);
        check("t2_count", 32'(COUNT), 1024);
        check("t2_ovfl0", 32'(OVFL),  0);
        PUSH = 1;
        tick();
        repeat (4) tick();
        check("t2_ovfl",   32'(OVFL),  1);
        check("t2_count2", 32'(COUNT), 1024);

        // Push and pop together while full; pushed entry must come out last.
        DAV = 7'h55; PUSH = 1;
        tick();
        wait_dp("t3_dp");
        if (head_ok()) POP = 1;
        tick();
        check("t3_count", 32'(COUNT),   1024);
        check("t3_err",   32'(FIFOERR), 0);
        drain(3000);

        // Pop on empty, then push with pop on empty.
        POP = 1;
        tick();
        check("t4_err",   32'(FIFOERR), 1);
        check("t4_count", 32'(COUNT),   0);
        check("t4_ovfl",  32'(OVFL),    1);
        PUSH = 1;
        tick();
        wait_dp("t4_dp");
        POP = 1;
        tick();
        check("t4_count1", 32'(COUNT),   1);
        check("t4_err2",   32'(FIFOERR), 1);
        drain(40);

        // BX wrap and BC0, with channel 0 killed.
        do_reset();
        PUSHDLY = '0; KILL = 7'h01; DAVDLY = 28'($urandom); AFULL_THR = 11'd4;
        for (int k = 0; k < 4000 && cyc < 3680; k++) begin
            DAV = 7'($urandom) | 7'h01;
            if (cyc == 100) BC0 = 1;
            if ((cyc >= 95 && cyc <= 104) || (cyc >= 3657 && cyc <= 3666)) PUSH = 1;
            if (head_ok()) begin
                check("t5_kill", 32'(DAVSOUT[0]), 0);
                POP = 1;
            end
            tick();
        end
        drain(60);
        KILL = '0;

        // Reset mid-burst at COUNT=5 with AFULL_THR=3.
        do_reset();
        AFULL_THR = 11'd3; PUSHDLY = '0;
        for (int k = 0; k < 20; k++) begin
            if (m_cnt == 5) break;
            DAV = 7'($urandom); PUSH = 1;
            tick();
        end
        check("t6_count5", 32'(COUNT), 5);
        check("t6_afull",  32'(AFULL), 1);
        do_reset();

        // Randomized traffic.
        PUSHDLY = 5'($urandom_range(0, 31)); DAVDLY = 28'($urandom);
        AFULL_THR = 11'($urandom_range(0, 12)); KILL = 7'($urandom);
        for (int k = 0; k < 3000; k++) begin
            DAV  = 7'($urandom);
            PUSH = ($urandom_range(0, 3) == 0);
            BC0  = ($urandom_range(0, 150) == 0);
            if (head_ok() && $urandom_range(0, 2) != 0) POP = 1;
            else if (m_cnt == 0 && $urandom_range(0, 20) == 0) POP = 1;
            if (k == 1500) begin
                DAVDLY = 28'($urandom); PUSHDLY = 5'($urandom_range(0, 31));
                KILL = 7'($urandom);
            end
            tick();
        end
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
